// File: rtl/ram_data_arbiter.sv
// Two-requester arbiter for the unified RAM data port: m0 is the CPU LSU, m1 the loader/debug port.
// The RAM read has one cycle of latency, and each response is sent back to the requester that issued it.
module ram_data_arbiter #(
    parameter int MEM_BYTES   = 16384,
    parameter int ROUND_ROBIN = 0,
    parameter int MAX_WAIT    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_req_we,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    input  logic [3:0]  m0_req_wstrb,
    input  logic        m0_req_lock,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_req_we,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    input  logic [3:0]  m1_req_wstrb,
    input  logic        m1_req_lock,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,
    output logic [31:0] ram_addr,
    output logic        ram_read,
    output logic        ram_write,
    output logic [3:0]  ram_wstrb,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    logic [1:0]  valid;
    logic        gnt_any;
    logic        gnt_id;
    logic        sel_we;
    logic        sel_lock;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        in_range;

    logic        rsp_pending;
    logic        rsp_owner;
    logic        rsp_err;
    logic        rsp_is_read;
    logic        last_grant;
    logic        lock_active;
    logic        lock_owner;
    logic [7:0]  wait_cnt;
    logic [31:0] rsp_data;

    assign valid = {m1_req_valid, m0_req_valid};

    // Every grant depends on rst_n, so no request is accepted while reset is held.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (rst_n) begin
            if (lock_active && valid[lock_owner]) begin
                gnt_any = 1'b1;
                gnt_id  = lock_owner;
            end else if (valid == 2'b01) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end else if (valid == 2'b10) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end else if (valid == 2'b11) begin
                gnt_any = 1'b1;
                if (ROUND_ROBIN != 0)
                    gnt_id = ~last_grant;
                else
                    gnt_id = (wait_cnt >= 8'(MAX_WAIT));
            end
        end
    end

    always_comb begin
        sel_we    = gnt_id ? m1_req_we    : m0_req_we;
        sel_lock  = gnt_id ? m1_req_lock  : m0_req_lock;
        sel_addr  = gnt_id ? m1_req_addr  : m0_req_addr;
        sel_wdata = gnt_id ? m1_req_wdata : m0_req_wdata;
        sel_wstrb = gnt_id ? m1_req_wstrb : m0_req_wstrb;
        in_range  = sel_addr < 32'(MEM_BYTES);
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wstrb = '0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        if (gnt_any) begin
            ram_addr  = sel_addr;
            ram_wdata = sel_wdata;
            ram_wstrb = sel_wstrb;
            ram_read  = !sel_we && in_range;
            ram_write = sel_we && in_range;
        end
    end

    assign m0_req_ready = gnt_any && !gnt_id;
    assign m1_req_ready = gnt_any && gnt_id;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_pending <= 1'b0;
            rsp_owner   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_is_read <= 1'b0;
            last_grant  <= 1'b1;
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            rsp_pending <= gnt_any;
            if (gnt_any) begin
                rsp_owner   <= gnt_id;
                rsp_err     <= !in_range;
                rsp_is_read <= !sel_we;
                last_grant  <= gnt_id;
                lock_active <= sel_lock;
                lock_owner  <= gnt_id;
            end else if (lock_active && !valid[lock_owner]) begin
                lock_active <= 1'b0;
            end
            if (ROUND_ROBIN == 0 && m1_req_valid && !(gnt_any && gnt_id)) begin
                if (wait_cnt != 8'hFF)
                    wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Writes and errors return zero data, so stale ram_rdata never reaches a requester.
    assign rsp_data = (rsp_is_read && !rsp_err) ? ram_rdata : '0;

    assign m0_rsp_valid = rst_n && rsp_pending && !rsp_owner;
    assign m1_rsp_valid = rst_n && rsp_pending && rsp_owner;
    assign m0_rsp_rdata = m0_rsp_valid ? rsp_data : '0;
    assign m1_rsp_rdata = m1_rsp_valid ? rsp_data : '0;
    assign m0_rsp_err   = m0_rsp_valid && rsp_err;
    assign m1_rsp_err   = m1_rsp_valid && rsp_err;

endmodule

// File: tb/tb_ram_data_arbiter.sv
// Scoreboard bench: instance 0 uses fixed priority and instance 1 uses round-robin, each with its own RAM model.
module tb_ram_data_arbiter;

    typedef struct {
        int          dut;
        int          owner;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]  v[2];
    logic [1:0]  we[2];
    logic [1:0]  lk[2];
    logic [31:0] ad[2][2];
    logic [31:0] wd[2][2];
    logic [3:0]  ws[2][2];

    logic [1:0]  rdy[2];
    logic [1:0]  rv[2];
    logic [1:0]  er[2];
    logic [31:0] rd[2][2];
    logic [31:0] r_addr[2];
    logic [31:0] r_wdata[2];
    logic [3:0]  r_wstrb[2];
    logic        r_read[2];
    logic        r_write[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : gd
        logic [31:0] mem [4096];
        logic [31:0] rdq;

        initial begin
            for (int i = 0; i < 4096; i++) mem[i] = '0;
            rdq = '0;
        end

        always @(posedge clk) begin
            if (r_write[g])
                for (int b = 0; b < 4; b++)
                    if (r_wstrb[g][b]) mem[r_addr[g][13:2]][8*b +: 8] <= r_wdata[g][8*b +: 8];
            if (r_read[g]) rdq <= mem[r_addr[g][13:2]];
        end

        ram_data_arbiter #(.MEM_BYTES(16384), .ROUND_ROBIN(g), .MAX_WAIT(8)) dut (
            .clk(clk), .rst_n(rst_n),
            .m0_req_valid(v[g][0]), .m0_req_ready(rdy[g][0]), .m0_req_we(we[g][0]),
            .m0_req_addr(ad[g][0]), .m0_req_wdata(wd[g][0]), .m0_req_wstrb(ws[g][0]),
            .m0_req_lock(lk[g][0]), .m0_rsp_valid(rv[g][0]), .m0_rsp_rdata(rd[g][0]),
            .m0_rsp_err(er[g][0]),
            .m1_req_valid(v[g][1]), .m1_req_ready(rdy[g][1]), .m1_req_we(we[g][1]),
            .m1_req_addr(ad[g][1]), .m1_req_wdata(wd[g][1]), .m1_req_wstrb(ws[g][1]),
            .m1_req_lock(lk[g][1]), .m1_rsp_valid(rv[g][1]), .m1_rsp_rdata(rd[g][1]),
            .m1_rsp_err(er[g][1]),
            .ram_addr(r_addr[g]), .ram_read(r_read[g]), .ram_write(r_write[g]),
            .ram_wstrb(r_wstrb[g]), .ram_wdata(r_wdata[g]), .ram_rdata(rdq)
        );
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int o = 0; o < 2; o++) begin
                if (rv[d][o] === 1'b1) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: dut%0d m%0d rsp_valid=1 expected none (cycle %0d)", d, o, cyc);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("rsp_route", 32'(d * 2 + o), 32'(e.dut * 2 + e.owner));
                        check("rsp_rdata", rd[d][o], e.rdata);
                        check("rsp_err", 32'(er[d][o]), 32'(e.err));
                        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            v[d] = '0; we[d] = '0; lk[d] = '0;
            for (int m = 0; m < 2; m++) begin
                ad[d][m] = '0; wd[d][m] = '0; ws[d][m] = '0;
            end
        end
    endtask

    task automatic drive(input int d, input int m, input logic w, input logic [31:0] a,
                         input logic [31:0] wdv, input logic [3:0] s, input logic l);
        v[d][m] = 1'b1; we[d][m] = w; ad[d][m] = a; wd[d][m] = wdv; ws[d][m] = s; lk[d][m] = l;
    endtask

    // Checks the grant and RAM strobes for this cycle and queues the expected response when a grant is made.
    task automatic step(input int d, input int m, input logic erd, input logic ewr,
                        input logic [31:0] exp_rdata, input logic exp_err, input string nm);
        logic [31:0] exp_addr;
        @(negedge clk);
        exp_addr = (m < 0) ? 32'h0 : ad[d][m];
        check({nm, "_ready"}, 32'(rdy[d]), (m < 0) ? 32'h0 : (32'h1 << m));
        check({nm, "_ramrw"}, 32'({r_read[d], r_write[d]}), 32'({erd, ewr}));
        check({nm, "_ramaddr"}, r_addr[d], exp_addr);
        if (m >= 0) sbq.push_back('{d, m, exp_rdata, exp_err, cyc + 1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_all();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        step(0, -1, 0, 0, 0, 0, "reset");
        rst_n = 1'b1;
        step(0, -1, 0, 0, 0, 0, "idle0");

        drive(0, 0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0);
        step(0, 0, 0, 1, 32'h0, 0, "wr100");
        drive(0, 0, 0, 32'h100, 32'h0, 4'h0, 0);
        step(0, 0, 1, 0, 32'hDEADBEEF, 0, "rd100");
        drive(0, 0, 1, 32'h104, 32'h11223344, 4'h3, 0);
        step(0, 0, 0, 1, 32'h0, 0, "wr104");
        drive(0, 0, 0, 32'h104, 32'h0, 4'h0, 0);
        step(0, 0, 1, 0, 32'h00003344, 0, "rd104");
        idle_all();
        step(0, -1, 0, 0, 0, 0, "idle1");

        drive(0, 0, 0, 32'h100, 32'h0, 4'h0, 0);
        drive(0, 1, 0, 32'h104, 32'h0, 4'h0, 0);
        for (int i = 0; i < 18; i++) begin
            if (i % 9 == 8) step(0, 1, 1, 0, 32'h00003344, 0, "starve_m1");
            else            step(0, 0, 1, 0, 32'hDEADBEEF, 0, "starve_m0");
        end
        idle_all();
        step(0, -1, 0, 0, 0, 0, "idle2");

        drive(0, 1, 0, 32'h4000, 32'h0, 4'h0, 0);
        step(0, 1, 0, 0, 32'h0, 1, "oor_rd");
        drive(0, 1, 1, 32'h4000, 32'hFFFFFFFF, 4'hF, 0);
        step(0, 1, 0, 0, 32'h0, 1, "oor_wr");
        drive(0, 1, 0, 32'h3FFC, 32'h0, 4'h0, 0);
        step(0, 1, 1, 0, 32'h0, 0, "edge_rd");
        drive(0, 1, 0, 32'h0, 32'h0, 4'h0, 0);
        step(0, 1, 1, 0, 32'h0, 0, "rd0_after_oor");
        idle_all();
        step(0, -1, 0, 0, 0, 0, "idle3");

        drive(0, 1, 0, 32'h104, 32'h0, 4'h0, 1);
        step(0, 1, 1, 0, 32'h00003344, 0, "lock_a");
        drive(0, 0, 0, 32'h100, 32'h0, 4'h0, 0);
        step(0, 1, 1, 0, 32'h00003344, 0, "lock_b");
        step(0, 1, 1, 0, 32'h00003344, 0, "lock_c");
        lk[0][1] = 1'b0;
        step(0, 1, 1, 0, 32'h00003344, 0, "lock_drop");
        step(0, 0, 1, 0, 32'hDEADBEEF, 0, "after_lock");
        idle_all();
        step(0, -1, 0, 0, 0, 0, "idle4");

        drive(1, 0, 1, 32'h200, 32'hA5A50001, 4'hF, 0);
        step(1, 0, 0, 1, 32'h0, 0, "rr_w0");
        idle_all();
        drive(1, 1, 1, 32'h300, 32'h5A5A0002, 4'hF, 0);
        step(1, 1, 0, 1, 32'h0, 0, "rr_w1");
        idle_all();
        drive(1, 0, 0, 32'h200, 32'h0, 4'h0, 0);
        drive(1, 1, 0, 32'h300, 32'h0, 4'h0, 0);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 1) step(1, 1, 1, 0, 32'h5A5A0002, 0, "rr_m1");
            else            step(1, 0, 1, 0, 32'hA5A50001, 0, "rr_m0");
        end
        idle_all();
        step(1, -1, 0, 0, 0, 0, "rr_idle");

        // An accepted read is followed by reset, so its response must be dropped.
        drive(0, 0, 0, 32'h100, 32'h0, 4'h0, 0);
        @(negedge clk);
        check("rst_acc_ready", 32'(rdy[0]), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        step(0, -1, 0, 0, 0, 0, "rst_hold");
        step(0, -1, 0, 0, 0, 0, "rst_hold2");
        idle_all();
        rst_n = 1'b1;
        step(0, -1, 0, 0, 0, 0, "post_rst");
        step(0, -1, 0, 0, 0, 0, "post_rst2");

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_data_arbiter.md
Name: ram_data_arbiter

Overview:
- Two-requester arbiter and sequencer for the data port of the 16 KB unified RAM.
- Requester 0 is the CPU load/store unit; requester 1 is the program loader/debug port.
- Presents a valid/ready request plus response-valid interface per requester, drives the RAM's registered-read data port, and routes each 1-cycle-latency read word back to its owner.
- Supports fixed or round-robin priority, an anti-starvation counter, bus lock, and out-of-range error responses.

Parameters:
- MEM_BYTES, 16384, size of the RAM; requests with addr >= MEM_BYTES are errors.
- ROUND_ROBIN, 0, 0 = m0 has fixed priority; 1 = alternate on contention.
- MAX_WAIT, 8, consecutive stalled cycles of m1 (fixed mode) before m1 is forced a grant; range 1..255.

Ports (X = 0,1; each line describes the pair):
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- mX_req_valid  input  1  request present.
- mX_req_ready  output  1  request accepted this cycle (combinational).
- mX_req_we  input  1  1 = write, 0 = read.
- mX_req_addr  input  32  byte address; RAM uses bits [13:2].
- mX_req_wdata  input  32  write data.
- mX_req_wstrb  input  4  byte-lane strobes for writes.
- mX_req_lock  input  1  keep the grant for the next request while asserted.
- mX_rsp_valid  output  1  one-cycle response pulse.
- mX_rsp_rdata  output  32  read word; 0 for writes and errors.
- mX_rsp_err  output  1  out-of-range access.
- ram_addr  output  32  to RAM data_address.
- ram_read  output  1  to RAM mem_read.
- ram_write  output  1  to RAM mem_write.
- ram_wstrb  output  4  to RAM mem_wstrb.
- ram_wdata  output  32  to RAM data_in.
- ram_rdata  input  32  from RAM data_out, valid 1 cycle after ram_read.

Behaviour:
- Reset (rst_n=0 at edge):
  - Clears rsp_pending, rsp_owner, rsp_err, last_grant (=1, so m0 wins first in round-robin mode), lock_owner (none), and wait_cnt (0).
  - While rst_n=0: all ready, ram_read, ram_write, and rsp_valid outputs are 0.
  - A response pending when reset is asserted is dropped and never emitted.
- Grant (combinational, every cycle, no idle bubble):
  - If lock_owner is set and that requester's valid=1, it wins.
  - Otherwise, if only one valid, it wins.
  - If both valid:
    - Fixed mode: m0 wins unless wait_cnt >= MAX_WAIT, in which case m1 wins.
    - Round-robin mode: the requester that is not last_grant wins.
  - Winner's req_ready=1; the loser's is 0.
- RAM drive for the granted request:
  - ram_addr = req_addr; ram_wdata and ram_wstrb pass through.
  - ram_read = !we && in_range; ram_write = we && in_range.
  - Out of range: no RAM strobe; the request is still accepted.
  - With no grant, all RAM strobes are 0 and ram_addr/ram_wdata/ram_wstrb are 0.
- Response pipeline: an accept in cycle N registers pending=1, owner, err, and is_read. In cycle N+1:
  - mOwner_rsp_valid=1.
  - rsp_rdata = ram_rdata if is_read && !err, else 0.
  - rsp_err = err.
  - Back-to-back accepts give one response per cycle in request order; the non-owner's rsp_valid is 0.
- Lock:
  - On accept with lock=1, lock_owner = winner.
  - lock_owner is cleared on an accept with lock=0, or on any cycle in which the owner's valid=0.
- Starvation counter (fixed mode only):
  - Increments when m1 is valid and not granted, saturating at 255.
  - Clears when m1 is granted or m1 is not valid.
- last_grant updates on every accept.
- Simultaneous events: same-address write then read in consecutive cycles returns the new data, since the RAM write and read resolve at separate edges.

Test Plan:
- Write m0 addr 0x100, wdata 0xDEADBEEF, wstrb 0xF, then read 0x100 → m0_rsp_valid one cycle after each accept; read rsp_rdata=0xDEADBEEF, err=0.
- Fixed mode, MAX_WAIT=8, both valid continuously → m0 granted 8 cycles, m1 granted on cycle 9, wait_cnt back to 0, pattern repeats.
- ROUND_ROBIN=1, both issue reads continuously → grants alternate m0, m1, m0…; each rsp_valid routed only to its owner with the correct word.
- m1 read at 0x4000 → no ram_read; m1_rsp_valid=1, rsp_err=1, rdata=0.
- m1 holds lock=1 for 3 accepts while m0 is valid → m0 stalled for 3 cycles; m0 granted on the cycle after m1 drops lock.
- Reset asserted the cycle after an accepted read → no rsp_valid; after release, all outputs are 0 until a new request.
